mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// M-stage data-memory access unit: decodes loads/stores, runs a single-outstanding
// request/response handshake on the data bus and returns the extended load result.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushM,
  input  logic        stall_allM,
  input  logic [31:0] instrM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] rt_valueM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall_req,
  output logic [31:0] mem_rdataM,
  output logic        addr_err_lM,
  output logic        addr_err_sM,
  output logic [31:0] badvaddrM,
  output logic [1:0]  state_dbg_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ADDR = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  // Bus handshake: a request is accepted in the cycle data_req && data_addr_ok;
  // exactly one data_data_ok (in WAIT_DATA) then completes that transaction.
  logic [1:0]  state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        wr_q, sign_q;

  logic [5:0]  op;
  logic        is_load, is_store, misalign, issue, load_done;
  logic [1:0]  op_size;
  logic [31:0] wdata_fmt, ld_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign op = instrM[31:26];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    op_size  = 2'd2;
    case (op)
      6'h20, 6'h24: begin is_load  = 1'b1; op_size = 2'd0; end
      6'h21, 6'h25: begin is_load  = 1'b1; op_size = 2'd1; end
      6'h23:        begin is_load  = 1'b1; op_size = 2'd2; end
      6'h28:        begin is_store = 1'b1; op_size = 2'd0; end
      6'h29:        begin is_store = 1'b1; op_size = 2'd1; end
      6'h2B:        begin is_store = 1'b1; op_size = 2'd2; end
      default:      ;
    endcase
  end

  assign misalign    = ((op_size == 2'd1) && alu_outM[0]) ||
                       ((op_size == 2'd2) && (alu_outM[1:0] != 2'b00));
  assign addr_err_lM = is_load && misalign;
  assign addr_err_sM = is_store && misalign;
  assign badvaddrM   = (addr_err_lM || addr_err_sM) ? alu_outM : 32'h0;

  // rst gates issue so data_req drops in the very cycle reset is applied.
  assign issue = !rst && (state_q == IDLE) && (is_load || is_store) && !misalign && !flushM;

  always_comb begin
    case (op_size)
      2'd0:    wdata_fmt = {4{rt_valueM[7:0]}};
      2'd1:    wdata_fmt = {2{rt_valueM[15:0]}};
      default: wdata_fmt = rt_valueM;
    endcase
  end

  assign data_req   = issue || (state_q == WAIT_ADDR);
  assign data_addr  = (state_q == IDLE) ? alu_outM   : addr_q;
  assign data_wr    = (state_q == IDLE) ? is_store   : wr_q;
  assign data_size  = (state_q == IDLE) ? op_size    : size_q;
  assign data_wdata = (state_q == IDLE) ? wdata_fmt  : wdata_q;
  assign stall_req  = issue || (state_q == WAIT_ADDR) || (state_q == WAIT_DATA);
  assign mem_rdataM  = rdata_q;
  assign state_dbg_o = state_q;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_v = data_rdata[7:0];
      2'd1:    byte_v = data_rdata[15:8];
      2'd2:    byte_v = data_rdata[23:16];
      default: byte_v = data_rdata[31:24];
    endcase
    half_v = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (size_q)
      2'd0:    ld_ext = {{24{sign_q & byte_v[7]}}, byte_v};
      2'd1:    ld_ext = {{16{sign_q & half_v[15]}}, half_v};
      default: ld_ext = data_rdata;
    endcase
  end

  // A flush seen at any point of the transaction (even alongside data_ok) drops it.
  assign load_done = (state_q == WAIT_DATA) && data_data_ok && !drop_q && !flushM;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (issue) state_d = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
      end
      WAIT_ADDR: begin
        if (flushM) drop_d = 1'b1;
        if (data_addr_ok) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flushM) drop_d = 1'b1;
        if (data_data_ok) begin
          state_d = (drop_q || flushM) ? IDLE : DONE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        if (!stall_allM) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (issue) begin
        addr_q  <= alu_outM;
        wdata_q <= wdata_fmt;
        size_q  <= op_size;
        wr_q    <= is_store;
        sign_q  <= ~op[2];
      end
      if (load_done) rdata_q <= wr_q ? 32'h0 : ld_ext;
    end
  end

endmodule
